paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Parametrised paddle controller for the pong datapath, clocked in the pixel domain. It holds one paddle's vertical position and moves it on a move-tick strobe from active-low keys or from an auto-track mode that follows the ball. Key-held acceleration and range clamping are built in. Every pixel clock it produces a registered in-paddle flag that the VGA colour mux consumes.

## Interface
- COORD_W, 12: width of all pixel coordinates.
- PAD_X, 630: left column of paddle.
- PAD_W, 5: paddle width in pixels.
- PAD_H, 70: paddle height in pixels.
- Y_MIN, 5: lowest allowed pad_y.
- Y_MAX, 400: highest allowed pad_y; must satisfy Y_MIN ≤ Y_INIT ≤ Y_MAX and Y_MAX+PAD_H < 2^COORD_W.
- Y_INIT, 205: pad_y after reset or while not started.
- STEP, 10: slow step per move tick.
- STEP_FAST, 20: step after acceleration.
- HOLD_TICKS, 8: consecutive same-direction ticks before switching to STEP_FAST.
- DEAD_BAND, 4: auto-mode tolerance in pixels.

Ports:
- vga_clk  in  1  the only clock; all logic is on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  game running; while low the paddle is parked at Y_INIT.
- move_tick  in  1  one-cycle strobe that enables one movement step.
- key_up_n  in  1  active-low; increases pad_y.
- key_dn_n  in  1  active-low; decreases pad_y.
- auto_en  in  1  1 = track ball_y, and keys are ignored.
- ball_y  in  COORD_W  ball top row, used in auto mode.
- pix_x  in  COORD_W  current scan column.
- pix_y  in  COORD_W  current scan row.
- pad_y  out  COORD_W  paddle top row (registered).
- moving  out  1  high for the cycle after any tick that changed pad_y.
- pad_hit  out  1  registered in-paddle pixel flag.

## Operation
- FSM states:
  - PARK: pad_y forced to Y_INIT; hold_cnt = 0. Goes to RUN when start = 1.
  - RUN: moves on move_tick. Goes to PARK when start = 0. The PARK transition and the pad_y reload happen on the same edge, so a move_tick on that cycle is ignored.
- Manual direction (RUN, auto_en = 0, move_tick = 1):
  - up = !key_up_n & key_dn_n.
  - dn = !key_dn_n & key_up_n.
  - Both pressed or neither pressed: no move, hold_cnt cleared.
- Step selection:
  - hold_cnt counts consecutive ticks in the same direction and saturates at HOLD_TICKS.
  - step = STEP_FAST when hold_cnt == HOLD_TICKS, otherwise STEP.
  - A direction change resets hold_cnt to 1.
- Clamping, computed with a COORD_W+1 intermediate:
  - up: pad_y = min(pad_y + step, Y_MAX).
  - dn: pad_y = (pad_y < Y_MIN + step) ? Y_MIN : pad_y − step. No wrap-around, ever.
- Auto mode (RUN, auto_en = 1, move_tick = 1):
  - target = ball_y − PAD_H/2 (signed, COORD_W+1), clamped to [Y_MIN, Y_MAX].
  - If |target − pad_y| ≤ DEAD_BAND: no move.
  - Otherwise move toward target by min(STEP, |diff|), so the paddle never overshoots.
  - hold_cnt is held at 0.
  - Toggling auto_en takes effect on the next tick.
- moving: set when a tick changes pad_y, cleared the next cycle. It stays 0 when a clamp produces no change.
- pad_hit: registered every cycle as (PAD_X ≤ pix_x < PAD_X+PAD_W) & (pad_y ≤ pix_y < pad_y+PAD_H). The pad_y used is the registered value from before the edge. Bounds are inclusive on the left/top and exclusive on the right/bottom.

## Timing
- Reset values: pad_y = Y_INIT, state = PARK, hold_cnt = 0, moving = 0, pad_hit = 0.
- Reset has priority over start and move_tick.
- Reset mid-move: the step in progress is discarded.
- pad_y updates on the edge where move_tick = 1; the new value is visible the following cycle. Latency is 1 cycle.
- pad_hit has 1-cycle latency from pix_x/pix_y. A pad_y change reaches pad_hit 2 cycles after its tick.
- move_tick held high for N cycles produces N steps; no edge detection is applied.
- Keys are expected to be debounced and synchronised upstream.

## Test plan
- Reset, start = 1, key_up_n = 0 for 3 ticks, default parameters → pad_y 215, 225, 235; moving pulses 1 cycle after each tick.
- pad_y = 395, key_up_n held → next tick pad_y = 400, following tick stays 400 with moving = 0. Mirror case: pad_y = 10, key_dn_n held → 5, then stays 5.
- key_up_n held for 10 ticks from 205 → ticks 1–7 add 10 each (reaching 275), ticks 8–10 add 20 each (reaching 335). Releasing then re-pressing restarts at STEP.
- auto_en = 1, ball_y = 300, pad_y = 205 → target 265; pad_y goes 215, 225, … 265, then holds. With ball_y = 268 (target 233, inside the dead band of 4) from pad_y 235 → no move.
- pad_y = 205, pix_x = 630, pix_y = 205 → pad_hit = 1 one cycle later. pix_y = 275 → 0. pix_x = 635 → 0.
- Both keys low → no motion. start dropped mid-run → pad_y = Y_INIT on the same edge. sys_rst pulsed with move_tick = 1 → pad_y = 205, pad_hit = 0.

Source files
------------

// File: rtl/paddle_ctrl.sv
// One paddle's vertical position, moved by keys (with hold acceleration) or by ball auto-tracking on move_tick.
// pad_y/moving update one cycle after the tick; pad_hit is a registered in-paddle flag for the colour mux.
module paddle_ctrl #(
  parameter int COORD_W    = 12,
  parameter int PAD_X      = 630,
  parameter int PAD_W      = 5,
  parameter int PAD_H      = 70,
  parameter int Y_MIN      = 5,
  parameter int Y_MAX      = 400,
  parameter int Y_INIT     = 205,
  parameter int STEP       = 10,
  parameter int STEP_FAST  = 20,
  parameter int HOLD_TICKS = 8,
  parameter int DEAD_BAND  = 4
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               move_tick,
  input  logic               key_up_n,
  input  logic               key_dn_n,
  input  logic               auto_en,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] pad_y,
  output logic               moving,
  output logic               pad_hit
);
  localparam int W1    = COORD_W + 1;
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);

  localparam logic [W1-1:0]          Y_MIN_U  = W1'(Y_MIN);
  localparam logic [W1-1:0]          Y_MAX_U  = W1'(Y_MAX);
  localparam logic [W1-1:0]          STEP_U   = W1'(STEP);
  localparam logic [W1-1:0]          FAST_U   = W1'(STEP_FAST);
  localparam logic [W1-1:0]          X_LO     = W1'(PAD_X);
  localparam logic [W1-1:0]          X_HI     = W1'(PAD_X + PAD_W);
  localparam logic [W1-1:0]          H_U      = W1'(PAD_H);
  localparam logic signed [W1-1:0]   Y_MIN_S  = W1'(Y_MIN);
  localparam logic signed [W1-1:0]   Y_MAX_S  = W1'(Y_MAX);
  localparam logic signed [W1-1:0]   HALF_S   = W1'(PAD_H / 2);
  localparam logic signed [W1-1:0]   BAND_S   = W1'(DEAD_BAND);
  localparam logic signed [W1-1:0]   STEP_S   = W1'(STEP);
  localparam logic [COORD_W-1:0]     Y_INIT_C = COORD_W'(Y_INIT);
  localparam logic [COORD_W-1:0]     Y_MIN_C  = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0]     Y_MAX_C  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0]     STEP_C   = COORD_W'(STEP);
  localparam logic [CNT_W-1:0]       HOLD_MAX = CNT_W'(HOLD_TICKS);

  typedef enum logic {PARK, RUN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    hold_cnt, hold_nxt, cnt_inc;
  logic                last_up, last_up_nxt;
  logic [COORD_W-1:0]  pad_y_nxt;
  logic                moving_nxt;
  logic                up, dn, hit_nxt;
  logic [W1-1:0]       pad_u, step_u, sum_u;
  logic [COORD_W-1:0]  up_y, dn_y, auto_y, amt;
  logic signed [W1-1:0] tgt_raw, tgt, diff, mag;

  assign pad_u = {1'b0, pad_y};
  assign up    = ~key_up_n & key_dn_n;
  assign dn    = ~key_dn_n & key_up_n;

  // hold_cnt only continues a run when the previous counted tick went the same way
  assign cnt_inc = (hold_cnt != '0 && last_up == up)
                 ? ((hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + CNT_W'(1))
                 : CNT_W'(1);
  assign step_u  = (cnt_inc == HOLD_MAX) ? FAST_U : STEP_U;
  assign sum_u   = pad_u + step_u;
  assign up_y    = (sum_u > Y_MAX_U) ? Y_MAX_C : sum_u[COORD_W-1:0];
  assign dn_y    = (pad_u < Y_MIN_U + step_u) ? Y_MIN_C : pad_y - step_u[COORD_W-1:0];

  // Target may go negative for a ball near the top, hence the signed path
  assign tgt_raw = $signed({1'b0, ball_y}) - HALF_S;
  assign tgt     = (tgt_raw < Y_MIN_S) ? Y_MIN_S : (tgt_raw > Y_MAX_S) ? Y_MAX_S : tgt_raw;
  assign diff    = tgt - $signed(pad_u);
  assign mag     = diff[W1-1] ? -diff : diff;
  assign amt     = (mag > STEP_S) ? STEP_C : mag[COORD_W-1:0];
  assign auto_y  = diff[W1-1] ? pad_y - amt : pad_y + amt;

  assign hit_nxt = ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                   ({1'b0, pix_y} >= pad_u) && ({1'b0, pix_y} < pad_u + H_U);

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    last_up_nxt = last_up;
    pad_y_nxt   = pad_y;
    moving_nxt  = 1'b0;
    case (state)
      PARK: begin
        pad_y_nxt = Y_INIT_C;
        hold_nxt  = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (!start) begin
          state_nxt = PARK;
          pad_y_nxt = Y_INIT_C;
          hold_nxt  = '0;
        end else if (move_tick) begin
          if (auto_en) begin
            hold_nxt = '0;
            if (mag > BAND_S) pad_y_nxt = auto_y;
          end else if (up || dn) begin
            hold_nxt    = cnt_inc;
            last_up_nxt = up;
            pad_y_nxt   = up ? up_y : dn_y;
          end else begin
            hold_nxt = '0;
          end
          moving_nxt = (pad_y_nxt != pad_y);
        end
      end
      default: state_nxt = PARK;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state    <= PARK;
      pad_y    <= Y_INIT_C;
      hold_cnt <= '0;
      last_up  <= 1'b0;
      moving   <= 1'b0;
      pad_hit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pad_y    <= pad_y_nxt;
      hold_cnt <= hold_nxt;
      last_up  <= last_up_nxt;
      moving   <= moving_nxt;
      pad_hit  <= hit_nxt;
    end
  end
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus random traffic, scored against a plain-arithmetic model.
module tb_paddle_ctrl;
  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1, start = 1'b0, move_tick = 1'b0;
  logic        key_up_n = 1'b1, key_dn_n = 1'b1, auto_en = 1'b0;
  logic [11:0] ball_y = '0, pix_x = '0, pix_y = '0;
  logic [11:0] pad_y;
  logic        moving, pad_hit;

  paddle_ctrl dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .start(start), .move_tick(move_tick),
    .key_up_n(key_up_n), .key_dn_n(key_dn_n), .auto_en(auto_en), .ball_y(ball_y),
    .pix_x(pix_x), .pix_y(pix_y), .pad_y(pad_y), .moving(moving), .pad_hit(pad_hit)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {int pad; int mv; int hit;} exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;

  // model state
  int m_pad = 205, m_hold = 0, m_dir = 0;
  bit m_run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge from the currently driven inputs.
  task automatic step();
    exp_t e;
    int np, hit, mv, tgt, d, dir, st, amt;
    int ux = int'(pix_x), uy = int'(pix_y);
    hit = (ux >= 630 && ux < 635 && uy >= m_pad && uy < m_pad + 70) ? 1 : 0;
    mv = 0;
    if (sys_rst) begin
      m_pad = 205; m_run = 0; m_hold = 0; m_dir = 0; hit = 0;
    end else if (!m_run || !start) begin
      m_pad = 205; m_hold = 0; m_dir = 0;
      m_run = !m_run && start;
    end else if (move_tick) begin
      np = m_pad;
      if (auto_en) begin
        tgt = int'(ball_y) - 35;
        if (tgt < 5) tgt = 5;
        if (tgt > 400) tgt = 400;
        d = tgt - m_pad;
        amt = (d < 0) ? -d : d;
        if (amt > 4) begin
          if (amt > 10) amt = 10;
          np = (d < 0) ? m_pad - amt : m_pad + amt;
        end
        m_hold = 0;
      end else begin
        dir = (!key_up_n && key_dn_n) ? 1 : (!key_dn_n && key_up_n) ? -1 : 0;
        if (dir == 0) m_hold = 0;
        else begin
          m_hold = (dir == m_dir && m_hold > 0) ? ((m_hold < 8) ? m_hold + 1 : 8) : 1;
          m_dir = dir;
          st = (m_hold == 8) ? 20 : 10;
          if (dir > 0) np = (m_pad + st > 400) ? 400 : m_pad + st;
          else np = (m_pad - st < 5) ? 5 : m_pad - st;
        end
      end
      mv = (np != m_pad) ? 1 : 0;
      m_pad = np;
    end
    e.pad = m_pad; e.mv = mv; e.hit = hit;
    sbq.push_back(e);
    @(negedge vga_clk);
  endtask

  // Monitor: outputs are presented every cycle, compared after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("mon_pad_y", int'(pad_y), e.pad);
        chk("mon_moving", int'(moving), e.mv);
        chk("mon_pad_hit", int'(pad_hit), e.hit);
      end
    end
  end

  initial begin
    int p, wait_cyc;
    @(negedge vga_clk);
    step(); step();
    chk("rst_pad_y", int'(pad_y), 205);
    chk("rst_moving", int'(moving), 0);
    chk("rst_pad_hit", int'(pad_hit), 0);

    sys_rst = 0; start = 1; step();
    chk("run_entry_pad_y", int'(pad_y), 205);

    key_up_n = 0;
    for (int k = 1; k <= 10; k++) begin
      move_tick = 1; step();
      chk("accel_pad_y", int'(pad_y), (k <= 7) ? 205 + 10 * k : 275 + 20 * (k - 7));
      chk("accel_moving", int'(moving), 1);
      move_tick = 0; step();
      chk("moving_clear", int'(moving), 0);
    end

    key_up_n = 1; move_tick = 1; step();
    chk("release_pad_y", int'(pad_y), 335);
    key_up_n = 0; step();
    chk("repress_slow", int'(pad_y), 345);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("climb_pad_y", int'(pad_y), 345 + 10 * k);
    end
    step();
    chk("clamp_max", int'(pad_y), 400);
    step();
    chk("clamp_hold", int'(pad_y), 400);
    chk("clamp_no_moving", int'(moving), 0);

    key_up_n = 1; start = 0; step();
    chk("park_same_edge", int'(pad_y), 205);
    chk("park_moving", int'(moving), 0);
    start = 1; step();
    chk("park_exit_ignores_tick", int'(pad_y), 205);

    key_dn_n = 0; p = 205;
    for (int k = 1; k <= 15; k++) begin
      step();
      p = (k <= 7) ? p - 10 : p - 20;
      if (p < 5) p = 5;
      chk("descend_pad_y", int'(pad_y), p);
    end
    chk("clamp_min_moving", int'(moving), 0);
    key_up_n = 0; step();
    chk("both_keys_pad_y", int'(pad_y), 5);
    chk("both_keys_moving", int'(moving), 0);
    key_up_n = 1; key_dn_n = 1;

    start = 0; move_tick = 0; step();
    start = 1; step();
    auto_en = 1; ball_y = 300; move_tick = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("auto_pad_y", int'(pad_y), 205 + 10 * k);
    end
    step();
    chk("auto_settled", int'(pad_y), 265);
    chk("auto_settled_moving", int'(moving), 0);
    ball_y = 270;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("auto_down", int'(pad_y), 265 - 10 * k);
    end
    ball_y = 268; step();
    chk("dead_band", int'(pad_y), 235);
    move_tick = 0;

    pix_x = 630; pix_y = 235; step();
    chk("hit_top_left", int'(pad_hit), 1);
    pix_y = 305; step();
    chk("hit_bottom_excl", int'(pad_hit), 0);
    pix_x = 634; pix_y = 304; step();
    chk("hit_bottom_right_in", int'(pad_hit), 1);
    pix_x = 635; step();
    chk("hit_right_excl", int'(pad_hit), 0);
    pix_x = 629; pix_y = 240; step();
    chk("hit_left_out", int'(pad_hit), 0);
    pix_x = 630; pix_y = 234; step();
    chk("hit_above", int'(pad_hit), 0);

    auto_en = 0; key_up_n = 0; move_tick = 1; sys_rst = 1; pix_y = 240; step();
    chk("rst_mid_move_pad_y", int'(pad_y), 205);
    chk("rst_mid_move_hit", int'(pad_hit), 0);
    chk("rst_mid_move_moving", int'(moving), 0);
    sys_rst = 0;

    for (int i = 0; i < 3000; i++) begin
      sys_rst = ($urandom_range(0, 199) == 0);
      if (start ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0)) start = ~start;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 7) == 0) key_up_n = ~key_up_n;
      if ($urandom_range(0, 7) == 0) key_dn_n = ~key_dn_n;
      move_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) ball_y = 12'($urandom_range(0, 520));
      pix_x = 12'($urandom_range(626, 638));
      pix_y = 12'(m_pad + int'($urandom_range(0, 84)) - 7);
      step();
    end

    move_tick = 0;
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 5) begin
      @(negedge vga_clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
